router_pkt_tx: RTL and testbench

Packet transmitter that drives the router's input port. It accepts a packet command (destination, length) and the payload bytes, and buffers the full payload. It then emits header, payload and parity on `pkt_vld`/`data_in`, stalling on the router's `busy`. It sits between a traffic source (testbench driver or upstream block) and the 1x3 router's input side.

---
 rtl/router_pkt_tx.sv | 228 ++++++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_tx
// Purpose  : Packet transmitter feeding the 1x3 router input port. Accepts a
//            command (destination, length), buffers the whole payload, then
//            emits header, payload and parity while honouring router busy.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous reset, active-high
//   cmd_vld_i     in   command valid
//   cmd_rdy_o     out  command ready (IDLE only)
//   cmd_addr_i    in   destination port 0..2
//   cmd_len_i     in   payload length 1..63
//   cmd_corrupt_i in   request inverted parity byte
//   pay_data_i    in   payload byte
//   pay_vld_i     in   payload byte valid
//   pay_rdy_o     out  payload ready (FILL only)
//   busy_i        in   router busy; a byte advances at an edge with busy=0
//   pkt_vld_o     out  packet valid to router
//   data_in_o     out  byte to router
//   tx_done_o     out  one-cycle pulse after parity is accepted
//   cmd_err_o     out  one-cycle pulse on a rejected command
//   pkt_cnt_o     out  packets sent, wraps at 16 bits
// Build option
//   TX_PARITY_CORRUPT_EN : when defined, a latched cmd_corrupt inverts the
//                          parity byte; otherwise cmd_corrupt_i is ignored.
// ============================================================================
module router_pkt_tx #(
   parameter int MAX_LEN = 63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_vld_i,
   output logic        cmd_rdy_o,
   input  logic [1:0]  cmd_addr_i,
   input  logic [5:0]  cmd_len_i,
   input  logic        cmd_corrupt_i,
   input  logic [7:0]  pay_data_i,
   input  logic        pay_vld_i,
   output logic        pay_rdy_o,
   input  logic        busy_i,
   output logic        pkt_vld_o,
   output logic [7:0]  data_in_o,
   output logic        tx_done_o,
   output logic        cmd_err_o,
   output logic [15:0] pkt_cnt_o
);

   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_FILL = 3'd1;
   localparam logic [2:0] c_HDR  = 3'd2;
   localparam logic [2:0] c_BODY = 3'd3;
   localparam logic [2:0] c_PAR  = 3'd4;
   localparam logic [2:0] c_GAP  = 3'd5;

   localparam logic [6:0] c_MAX_LEN = 7'(MAX_LEN);

   logic [2:0]  state_q, state_d;
   logic [1:0]  addr_q, addr_d;
   logic [5:0]  len_q, len_d;
   logic [7:0]  par_q, par_d;
   logic [5:0]  wr_idx_q, wr_idx_d;
   logic [5:0]  rd_idx_q, rd_idx_d;
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic        cmd_rdy_q, cmd_rdy_d;
   logic        pay_rdy_q, pay_rdy_d;
   logic        pkt_vld_q, pkt_vld_d;
   logic [7:0]  data_q, data_d;
   logic        tx_done_q, tx_done_d;
   logic        cmd_err_q, cmd_err_d;
   logic [7:0]  buf_q [MAX_LEN];
   logic        w_cmd_bad;
   logic [7:0]  w_par_out;

`ifdef TX_PARITY_CORRUPT_EN
   logic corrupt_q, corrupt_d;
   assign w_par_out = par_d ^ {8{corrupt_d}};
`else
   logic w_unused_corrupt;
   assign w_unused_corrupt = cmd_corrupt_i;
   assign w_par_out        = par_d;
`endif

   // Length is also bounded by the buffer depth so a reduced MAX_LEN build
   // can never index past the end of the buffer.
   assign w_cmd_bad = (cmd_addr_i == 2'd3) || (cmd_len_i == 6'd0) ||
                      ({1'b0, cmd_len_i} > c_MAX_LEN);

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= c_IDLE;
         addr_q    <= 2'd0;
         len_q     <= 6'd0;
         par_q     <= 8'h00;
         wr_idx_q  <= 6'd0;
         rd_idx_q  <= 6'd0;
         pkt_cnt_q <= 16'd0;
         cmd_rdy_q <= 1'b1;
         pay_rdy_q <= 1'b0;
         pkt_vld_q <= 1'b0;
         data_q    <= 8'h00;
         tx_done_q <= 1'b0;
         cmd_err_q <= 1'b0;
`ifdef TX_PARITY_CORRUPT_EN
         corrupt_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         par_q     <= par_d;
         wr_idx_q  <= wr_idx_d;
         rd_idx_q  <= rd_idx_d;
         pkt_cnt_q <= pkt_cnt_d;
         cmd_rdy_q <= cmd_rdy_d;
         pay_rdy_q <= pay_rdy_d;
         pkt_vld_q <= pkt_vld_d;
         data_q    <= data_d;
         tx_done_q <= tx_done_d;
         cmd_err_q <= cmd_err_d;
`ifdef TX_PARITY_CORRUPT_EN
         corrupt_q <= corrupt_d;
`endif
      end
   end

   // Payload buffer; contents are don't-care after reset, so no reset term.
   always_ff @(posedge clk) begin
      if (state_q == c_FILL && pay_vld_i) begin
         buf_q[wr_idx_q] <= pay_data_i;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      par_d     = par_q;
      wr_idx_d  = wr_idx_q;
      rd_idx_d  = rd_idx_q;
      pkt_cnt_d = pkt_cnt_q;
`ifdef TX_PARITY_CORRUPT_EN
      corrupt_d = corrupt_q;
`endif
      case (state_q)
         c_IDLE: begin
            if (cmd_vld_i) begin
               addr_d = cmd_addr_i;
               len_d  = cmd_len_i;
`ifdef TX_PARITY_CORRUPT_EN
               corrupt_d = cmd_corrupt_i;
`endif
               if (!w_cmd_bad) begin
                  state_d  = c_FILL;
                  par_d    = {cmd_len_i, cmd_addr_i};
                  wr_idx_d = 6'd0;
               end
            end
         end
         c_FILL: begin
            if (pay_vld_i) begin
               par_d    = par_q ^ pay_data_i;
               wr_idx_d = wr_idx_q + 6'd1;
               if (wr_idx_q == len_q - 6'd1) begin
                  state_d = c_HDR;
               end
            end
         end
         c_HDR: begin
            if (!busy_i) begin
               state_d  = c_BODY;
               rd_idx_d = 6'd0;
            end
         end
         c_BODY: begin
            if (!busy_i) begin
               rd_idx_d = rd_idx_q + 6'd1;
               if (rd_idx_q == len_q - 6'd1) begin
                  state_d = c_PAR;
               end
            end
         end
         c_PAR: begin
            if (!busy_i) begin
               state_d   = c_GAP;
               pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
         end
         c_GAP: begin
            if (!busy_i) begin
               state_d = c_IDLE;
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   // Registered outputs are computed from the upcoming state so they line up
   // with the state they describe.
   always_comb begin
      cmd_rdy_d = (state_d == c_IDLE);
      pay_rdy_d = (state_d == c_FILL);
      pkt_vld_d = (state_d == c_HDR) || (state_d == c_BODY);
      tx_done_d = (state_q == c_PAR) && (state_d == c_GAP);
      cmd_err_d = (state_q == c_IDLE) && cmd_vld_i && w_cmd_bad;
      data_d    = 8'h00;
      case (state_d)
         c_HDR:   data_d = {len_d, addr_d};
         c_BODY:  data_d = buf_q[rd_idx_d];
         c_PAR:   data_d = w_par_out;
         default: data_d = 8'h00;
      endcase
   end

   assign cmd_rdy_o = cmd_rdy_q;
   assign pay_rdy_o = pay_rdy_q;
   assign pkt_vld_o = pkt_vld_q;
   assign data_in_o = data_q;
   assign tx_done_o = tx_done_q;
   assign cmd_err_o = cmd_err_q;
   assign pkt_cnt_o = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_pkt_tx
// Purpose  : Self-checking bench for router_pkt_tx. Directed cases plus
//            randomized packets against a beat-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_pkt_tx;

`ifdef TX_PARITY_CORRUPT_EN
   localparam bit CORRUPT_ON = 1'b1;
`else
   localparam bit CORRUPT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_vld = 1'b0;
   logic [1:0]  cmd_addr = 2'd0;
   logic [5:0]  cmd_len = 6'd0;
   logic        cmd_corrupt = 1'b0;
   logic [7:0]  pay_data = 8'h00;
   logic        pay_vld = 1'b0;
   logic        busy = 1'b0;
   logic        cmd_rdy, pay_rdy, pkt_vld, tx_done, cmd_err;
   logic [7:0]  data_in;
   logic [15:0] pkt_cnt;

   always #5 clk = ~clk;

   router_pkt_tx #(.MAX_LEN(63)) dut (
      .clk(clk), .rst(rst),
      .cmd_vld_i(cmd_vld), .cmd_rdy_o(cmd_rdy),
      .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_corrupt_i(cmd_corrupt),
      .pay_data_i(pay_data), .pay_vld_i(pay_vld), .pay_rdy_o(pay_rdy),
      .busy_i(busy), .pkt_vld_o(pkt_vld), .data_in_o(data_in),
      .tx_done_o(tx_done), .cmd_err_o(cmd_err), .pkt_cnt_o(pkt_cnt)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [8:0]  beats[$];     // expected {pkt_vld, data_in} per transmitted byte
   logic [7:0]  obs[$];       // bytes observed as accepted by the router
   logic [15:0] model_cnt = 16'd0;
   bit          done_pending = 1'b0;
   int          done_seen = 0;
   int          busy_mode = 0;
   bit          stall_arm = 1'b0;
   int          stall_cnt = 0;
   int          cnt22 = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Compare process: outputs are sampled on the falling edge; busy only
   // changes just after the rising edge, so the value seen here is the one
   // the next rising edge uses.
   always @(negedge clk) begin
      check("tx_done", {31'd0, tx_done}, {31'd0, done_pending});
      check("pkt_cnt", {16'd0, pkt_cnt}, {16'd0, model_cnt});
      if (tx_done) done_seen++;
      if (beats.size() > 0) begin
         check("pkt_vld", {31'd0, pkt_vld}, {31'd0, beats[0][8]});
         check("data_in", {24'd0, data_in}, {24'd0, beats[0][7:0]});
      end else begin
         check("quiet_pkt_vld", {31'd0, pkt_vld}, 32'd0);
         check("quiet_data_in", {24'd0, data_in}, 32'd0);
      end
      if (pkt_vld && data_in == 8'h22) cnt22++;
      if (rst) begin
         beats.delete();
         done_pending = 1'b0;
         model_cnt    = 16'd0;
      end else begin
         done_pending = 1'b0;
         if (beats.size() > 0 && !busy) begin
            obs.push_back(data_in);
            void'(beats.pop_front());
            if (beats.size() == 0) begin
               done_pending = 1'b1;
               model_cnt    = model_cnt + 16'd1;
            end
         end
      end
   end

   // Router busy emulation: random, or a directed 3-cycle stall on byte 0x22.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (stall_cnt > 0) begin
            busy = 1'b1;
            stall_cnt--;
         end else if (stall_arm && pkt_vld && data_in == 8'h22) begin
            stall_arm = 1'b0;
            busy      = 1'b1;
            stall_cnt = 2;
         end else if (busy_mode == 1) begin
            busy = ($urandom_range(0, 3) == 0);
         end else begin
            busy = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic push_expect(input logic [1:0] a, input logic [5:0] l,
                              input bit corr, input logic [7:0] pay[$]);
      logic [7:0] p;
      p = {l, a};
      beats.push_back({1'b1, l, a});
      foreach (pay[i]) begin
         beats.push_back({1'b1, pay[i]});
         p = p ^ pay[i];
      end
      if (corr && CORRUPT_ON) p = ~p;
      beats.push_back({1'b0, p});
   endtask

   task automatic wait_cmd_rdy();
      int t = 0;
      while (cmd_rdy !== 1'b1 && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      check("cmd_rdy_wait", {31'd0, cmd_rdy}, 32'd1);
   endtask

   task automatic wait_done();
      int t = 0;
      int d0 = done_seen;
      while (!(beats.size() == 0 && done_seen > d0) && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      check("tx_done_seen", {31'd0, (done_seen > d0)}, 32'd1);
   endtask

   // Issues one command (caller is just after a rising edge), fills payload
   // with the given idle gaps before each byte, and optionally waits for done.
   task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input bit corr,
                          input logic [7:0] pay[$], input int gaps[$], input bit no_wait);
      wait_cmd_rdy();
      check("pay_rdy_idle", {31'd0, pay_rdy}, 32'd0);
      cmd_vld = 1'b1; cmd_addr = a; cmd_len = l; cmd_corrupt = corr;
      @(posedge clk); #1;
      cmd_vld = 1'b0; cmd_corrupt = 1'b0;
      if (a == 2'd3 || l == 6'd0) begin
         check("cmd_err", {31'd0, cmd_err}, 32'd1);
         check("cmd_rdy_err", {31'd0, cmd_rdy}, 32'd1);
         @(posedge clk); #1;
         check("cmd_err_pulse", {31'd0, cmd_err}, 32'd0);
         check("cmd_rdy_err2", {31'd0, cmd_rdy}, 32'd1);
         return;
      end
      check("cmd_err_quiet", {31'd0, cmd_err}, 32'd0);
      for (int k = 0; k < int'(l); k++) begin
         int g = (k < gaps.size()) ? gaps[k] : 0;
         repeat (g) begin
            pay_vld = 1'b0;
            check("pay_rdy_gap", {31'd0, pay_rdy}, 32'd1);
            @(posedge clk); #1;
         end
         pay_vld  = 1'b1;
         pay_data = pay[k];
         check("pay_rdy_fill", {31'd0, pay_rdy}, 32'd1);
         check("cmd_rdy_fill", {31'd0, cmd_rdy}, 32'd0);
         @(posedge clk); #1;
      end
      pay_vld = 1'b0;
      check("pay_rdy_done", {31'd0, pay_rdy}, 32'd0);
      push_expect(a, l, corr, pay);
      if (!no_wait) wait_done();
   endtask

   task automatic check_basic_obs(input logic [7:0] par);
      logic [7:0] exp_b[5];
      exp_b[0] = 8'h0D; exp_b[1] = 8'h11; exp_b[2] = 8'h22; exp_b[3] = 8'h33; exp_b[4] = par;
      check("obs_len", obs.size(), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check("obs_byte", (i < obs.size()) ? {24'd0, obs[i]} : 32'hFFFF_FFFF, {24'd0, exp_b[i]});
      end
   endtask

   initial begin
      logic [7:0] pay[$];
      logic [7:0] none[$];
      int         gaps[$];
      int         t;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
      check("rst_pay_rdy", {31'd0, pay_rdy}, 32'd0);
      check("rst_pkt_vld", {31'd0, pkt_vld}, 32'd0);
      check("rst_data_in", {24'd0, data_in}, 32'd0);
      check("rst_tx_done", {31'd0, tx_done}, 32'd0);
      check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
      check("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic packet
      pay = '{8'h11, 8'h22, 8'h33};
      gaps = '{0, 0, 0};
      obs.delete();
      run_pkt(2'd1, 6'd3, 1'b0, pay, gaps, 1'b0);
      check_basic_obs(8'h0D);
      check("basic_cnt", {16'd0, pkt_cnt}, 32'd1);

      // Stall on 0x22
      obs.delete(); cnt22 = 0; stall_arm = 1'b1;
      run_pkt(2'd1, 6'd3, 1'b0, pay, gaps, 1'b0);
      check("stall_hold", cnt22, 32'd4);
      check_basic_obs(8'h0D);
      check("stall_cnt", {16'd0, pkt_cnt}, 32'd2);

      // Rejected commands
      run_pkt(2'd3, 6'd5, 1'b0, none, gaps, 1'b0);
      run_pkt(2'd0, 6'd0, 1'b0, none, gaps, 1'b0);
      check("reject_cnt", {16'd0, pkt_cnt}, 32'd2);

      // Payload gaps: pay_vld pattern 1,0,0,1,0,1
      obs.delete();
      gaps = '{0, 2, 1};
      run_pkt(2'd1, 6'd3, 1'b0, pay, gaps, 1'b0);
      check_basic_obs(8'h0D);

      // Parity corrupt request
      obs.delete();
      gaps = '{0, 0, 0};
      run_pkt(2'd1, 6'd3, 1'b1, pay, gaps, 1'b0);
      check_basic_obs(CORRUPT_ON ? 8'hF2 : 8'h0D);

      // Reset while payload byte 2 of a len=10 packet is driven
      pay.delete();
      for (int i = 0; i < 10; i++) pay.push_back(8'($urandom));
      run_pkt(2'd2, 6'd10, 1'b0, pay, gaps, 1'b1);
      t = 0;
      while (beats.size() != 9 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("rst_mid_reach", {31'd0, (beats.size() == 9)}, 32'd1);
      check("rst_mid_byte2", {24'd0, data_in}, {24'd0, pay[2]});
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_pkt_vld", {31'd0, pkt_vld}, 32'd0);
      check("rst_mid_data_in", {24'd0, data_in}, 32'd0);
      check("rst_mid_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
      check("rst_mid_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
      pay = '{8'h11, 8'h22, 8'h33};
      obs.delete();
      run_pkt(2'd1, 6'd3, 1'b0, pay, gaps, 1'b0);
      check_basic_obs(8'h0D);
      check("after_rst_cnt", {16'd0, pkt_cnt}, 32'd1);

      // Randomized traffic with random router busy
      busy_mode = 1;
      for (int n = 0; n < 40; n++) begin
         logic [1:0] a;
         logic [5:0] l;
         a = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         case ($urandom_range(0, 9))
            0:       l = 6'd0;
            1:       l = 6'($urandom_range(40, 63));
            default: l = 6'($urandom_range(1, 12));
         endcase
         pay.delete(); gaps.delete();
         for (int i = 0; i < int'(l); i++) begin
            pay.push_back(8'($urandom));
            gaps.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
         end
         run_pkt(a, l, 1'($urandom_range(0, 1)), pay, gaps, 1'b0);
      end
      busy_mode = 0;
      repeat (5) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
